// File: rtl/hamming_sec_enc_stream.sv
// Streaming Hamming(12,8) SEC encoder feeding a 2-entry FIFO with registered handshake outputs.
// Define ERR_INJECT_EN to add inj_arm/inj_pos single-bit fault injection on the stored codeword.
module hamming_sec_enc_stream (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ERR_INJECT_EN
    input  logic        inj_arm,
    input  logic [3:0]  inj_pos,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_code,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e            state_q, state_d;
    logic [1:0][11:0]  mem_q, mem_d;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic              in_ready_q, out_valid_q;
    logic [11:0]       out_code_q;
    logic [15:0]       cnt_q;
    logic              push, pop;
    logic [11:0]       code_w, inj_mask;

    function automatic logic [11:0] enc(input logic [7:0] d);
        logic [11:0] c;
        c[2]  = d[0];  c[4]  = d[1];  c[5]  = d[2];  c[6]  = d[3];
        c[8]  = d[4];  c[9]  = d[5];  c[10] = d[6];  c[11] = d[7];
        c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
        return c;
    endfunction

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

`ifdef ERR_INJECT_EN
    logic        arm_q;
    logic [3:0]  pos_q;
    logic        arm_eff;
    logic [3:0]  pos_eff;
    logic [15:0] pos_oh;

    // An arm pulse coinciding with a push corrupts that same word.
    assign arm_eff  = arm_q | inj_arm;
    assign pos_eff  = inj_arm ? inj_pos : pos_q;
    assign pos_oh   = 16'd1 << pos_eff;
    assign inj_mask = arm_eff ? pos_oh[11:0] : 12'h000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= 1'b0;
            pos_q <= 4'd0;
        end else if (push) begin
            arm_q <= 1'b0;
        end else if (inj_arm) begin
            arm_q <= 1'b1;
            pos_q <= inj_pos;
        end
    end
`else
    assign inj_mask = 12'h000;
`endif

    assign code_w = enc(in_data) ^ inj_mask;

    always_comb begin
        mem_d  = mem_q;
        if (push) mem_d[wptr_q] = code_w;
        wptr_d = wptr_q ^ push;
        rptr_d = rptr_q ^ pop;
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE:     if (push && !pop) state_d = FULL;
                     else if (pop && !push) state_d = EMPTY;
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Outputs are registered from next-state so a push into an empty FIFO is visible right after its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            mem_q       <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_code_q  <= 12'h000;
            cnt_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            out_code_q  <= mem_d[rptr_d];
            if (pop) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_code   = out_code_q;
    assign word_count = cnt_q;

endmodule

// File: doc/hamming_sec_enc_stream.md
HAMMING_SEC_ENC_STREAM -- requirements
Module: hamming_sec_enc_stream

Interface
- REQ-001 The block SHALL have one clock and one asynchronous, active-low reset; the ports SHALL be clk and rst_n.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 rst_n  input  1  asynchronous active-low reset.
- REQ-004 in_valid  input  1  in_data holds a data byte to encode.
- REQ-005 in_ready  output  1  block can accept a byte this cycle.
- REQ-006 in_data  input  8  data byte d[7:0].
- REQ-007 out_valid  output  1  out_code holds a codeword.
- REQ-008 out_ready  input  1  the consumer accepts out_code this cycle.
- REQ-009 out_code  output  12  SEC codeword.
- REQ-010 word_count  output  16  number of codewords accepted at the output.
- REQ-011 With ERR_INJECT_EN defined, the block SHALL add these inputs, with no other port change:
  - inj_arm  input  1
  - inj_pos  input  4

Function
- REQ-012 Codeword bit mapping SHALL be:
  - data: code[2]=d0, code[4]=d1, code[5]=d2, code[6]=d3, code[8]=d4, code[9]=d5, code[10]=d6, code[11]=d7.
  - parity: code[0], code[1], code[3], code[7].
- REQ-013 The parity bits SHALL be:
  - code[0]=d0^d1^d3^d4^d6
  - code[1]=d0^d2^d3^d5^d6
  - code[3]=d1^d2^d3^d7
  - code[7]=d4^d5^d6^d7
- REQ-014 An input handshake SHALL occur on a rising edge where in_valid and in_ready are both high; an output handshake SHALL occur where out_valid and out_ready are both high.
- REQ-015 Encoding SHALL be computed at the input handshake. The codeword SHALL be written into a 2-entry FIFO.
- REQ-016 Latency: a byte accepted at edge N SHALL appear on out_code with out_valid high from just after edge N, if the FIFO was empty.
- REQ-017 FIFO occupancy SHALL follow a 3-state machine:
  - EMPTY->ONE on push only.
  - ONE->FULL on push only.
  - ONE->EMPTY on pop only.
  - FULL->ONE on pop.
  - ONE->ONE on simultaneous push and pop.
- REQ-018 in_ready SHALL be high in EMPTY and ONE and low in FULL. It SHALL be driven from state, with no combinational path from out_ready.
- REQ-019 out_valid SHALL be high in ONE and FULL. out_code SHALL be the oldest entry, and SHALL be held stable while out_valid is high and out_ready is low.
- REQ-020 In ONE with simultaneous push and pop, the popped word SHALL be the old entry, and the new word SHALL become the head on the next cycle.
- REQ-021 Read and write pointers SHALL be 1 bit wide and wrap 1->0. Order SHALL be strictly FIFO.
- REQ-022 word_count SHALL increment by 1 on each output handshake and wrap from 0xFFFF to 0x0000.
- REQ-023 in_data SHALL be ignored when no input handshake occurs; out_ready SHALL be ignored when out_valid is low.

Reset
- REQ-024 On rst_n low, asynchronously:
  - state=EMPTY and both pointers=0;
  - in_ready=0, out_valid=0, out_code=0x000, word_count=0;
  - the injection arm flag=0.
- REQ-025 In the first cycle after rst_n deasserts, in_ready SHALL go to 1.
- REQ-026 Reset asserted mid-operation SHALL discard all buffered words. No partial output SHALL appear after release.

Configuration
- REQ-027 Macro ERR_INJECT_EN SHALL compile in fault injection:
  - inj_arm high for one cycle SHALL set an internal arm flag and latch inj_pos.
  - The next input handshake SHALL store the codeword with bit inj_pos inverted.
  - That handshake SHALL then clear the arm flag.
  - inj_pos values 12-15 SHALL inject nothing but SHALL still clear the flag.
  - If inj_arm coincides with a handshake, that same word SHALL be corrupted.
- REQ-028 Without ERR_INJECT_EN, inj_arm and inj_pos SHALL NOT exist, and codewords SHALL always be clean.

Verification
- REQ-029 Encoding check, with out_ready=1:
  - in_data 0x00 -> out_code 0x000.
  - 0x01 -> 0x007.
  - 0x80 -> 0x888.
  - 0xFF -> 0xF77.
  - Each appears one cycle after the handshake.
- REQ-030 Backpressure:
  - out_ready=0, push 0x01 then 0x80 -> in_ready goes to 0 after the second push.
  - out_code holds 0x007.
  - Release out_ready -> 0x007 then 0x888; word_count=2.
- REQ-031 Simultaneous push and pop in ONE:
  - Head 0xF77 is popped while 0x01 is pushed.
  - Next cycle out_code=0x007, and state stays ONE.
- REQ-032 Reset mid-stream:
  - Assert rst_n low with FULL.
  - Required: out_valid=0, word_count=0 immediately.
  - After release: in_ready=1, and no stale word appears.
- REQ-033 word_count wrap: after 65536 output handshakes, word_count=0x0000.
- REQ-034 ERR_INJECT_EN:
  - Arm with inj_pos=5, push 0xFF -> out_code 0xF57.
  - The next push of 0xFF -> 0xF77.
  - Feeding both into the existing SEC decoder -> 0xFF, with error_corrected=1 then 0.
